alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Command-driven controller that sequences the 8-bit ALU datapath. It accepts LOAD_A / LOAD_B / EXEC / CLEAR commands through a valid/ready port and buffers them in a small FIFO. It drives the ALU operand, select and shift inputs, waits for the ALU to settle, then captures the result and flags into a result register. The captured result is presented on a valid/ready output, and a sticky flag summary is maintained. The block sits between the pin-level input logic and the ALU/flag display, replacing direct switch-to-operand loading.

Parameters:
QDEPTH, 4, command FIFO depth; power of two, minimum 2.
ALU_LAT, 1, settle cycles between driving an EXEC and capturing the result; minimum 1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; when low, the FSM and FIFO push/pop are frozen
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted this cycle when high together with cmd_valid
cmd_type  in  2  00 LOAD_A, 01 LOAD_B, 10 EXEC, 11 CLEAR
cmd_data  in  8  operand byte for LOAD_A/LOAD_B; ignored otherwise
cmd_op  in  3  ALU select for EXEC
cmd_shift  in  4  ALU shift amount for EXEC
alu_a  out  8  registered operand A to ALU
alu_b  out  8  registered operand B to ALU
alu_s  out  3  registered ALU select
alu_shift  out  4  registered ALU shift
alu_y  in  8  ALU result (combinational from alu_* outputs)
alu_zero, alu_carry, alu_overflow  in  1 each  ALU flags
res_valid  out  1  result available
res_ready  in  1  result consumed when high together with res_valid
res_y  out  8  captured result
res_flags  out  3  captured {overflow, carry, zero}
sticky_flags  out  3  OR of all res_flags captured since reset/CLEAR
busy  out  1  high when FSM is not in IDLE or the FIFO is non-empty
q_level  out  clog2(QDEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n low): all outputs 0; FIFO empty; FSM to IDLE; settle counter 0. Reset mid-operation aborts the command in flight with no capture.
- cmd_ready = ena && !full, evaluated on the registered occupancy. A push on a full FIFO cannot occur, even when a pop happens in the same cycle. Push and pop in the same cycle leave q_level unchanged.
- FIFO entry = {type, data, op, shift}, 17 bits. Pointers wrap modulo QDEPTH.
- FSM states: IDLE, DECODE, SETTLE, CAPTURE, HOLD. All transitions are gated by ena; while ena is low, state, counters and outputs hold.
- IDLE: if the FIFO is non-empty, pop the head into the current-command register and go to DECODE. A command pushed into an empty FIFO is popped no earlier than the next cycle.
- DECODE, LOAD_A: alu_a <= data, then IDLE.
- DECODE, LOAD_B: alu_b <= data, then IDLE.
- DECODE, CLEAR: alu_a, alu_b, alu_s, alu_shift and sticky_flags <= 0, then IDLE. res_y and res_flags are not changed.
- DECODE, EXEC: alu_s <= op, alu_shift <= shift, counter <= ALU_LAT-1, then SETTLE.
- SETTLE: decrement the counter; at 0 go to CAPTURE.
- CAPTURE:
  - if res_valid is low: res_y <= alu_y; res_flags <= {ovf, carry, zero}; sticky_flags |= the same value; res_valid <= 1; then IDLE.
  - if res_valid is still high (unconsumed result): go to HOLD without capturing.
- HOLD: when res_valid drops, perform the CAPTURE actions and go to IDLE. The ALU inputs stay stable throughout HOLD.
- res_valid clears on the cycle after res_valid && res_ready. A new capture in that same cycle is not allowed; CAPTURE/HOLD see the registered res_valid.
- Throughput:
  - LOAD and CLEAR: 2 cycles per command (IDLE, DECODE).
  - EXEC: 3+ALU_LAT cycles from pop to res_valid with no back-pressure.
- The ALU is never driven with a partially updated op; alu_s and alu_shift change only in DECODE.
- busy is combinational from state and occupancy.

Test Plan:
1. Push LOAD_A 0x3C, LOAD_B 0x0F, EXEC op=000 against a bench ALU model (000 = add), res_ready=1 -> alu_a=0x3C, alu_b=0x0F; res_y=0x4B; res_flags=000; res_valid goes high 3+ALU_LAT cycles after the EXEC pop.
2. LOAD_A 0xFF, LOAD_B 0x01, EXEC add -> res_y=0x00, res_flags=011 (carry, zero); then LOAD_A 0x7F, EXEC add -> res_y=0x80, overflow set, sticky_flags=111.
3. Hold res_ready=0 and push 2+QDEPTH EXECs -> FSM waits in HOLD; cmd_ready drops once q_level=QDEPTH; pulse res_ready once per result -> all results are delivered in order with none lost or duplicated.
4. CLEAR after scenario 2 -> alu_a/alu_b/alu_s/alu_shift=0 and sticky_flags=000; res_y keeps its last value.
5. Drop ena for 4 cycles during SETTLE with ALU_LAT=3 -> no state change and cmd_ready=0; on resume the capture occurs exactly as in an uninterrupted run, offset by 4 cycles.
6. Assert rst_n low asynchronously mid-SETTLE with 2 commands queued -> all outputs 0, q_level=0, res_valid=0 immediately; after release, a new LOAD_A 0x55 works normally.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
`timescale 1ns/1ps
// alu_cmd_sequencer
// Command-driven controller for the 8-bit ALU datapath. Commands (LOAD_A, LOAD_B, EXEC, CLEAR)
// arrive on a valid/ready port and are buffered in a QDEPTH-entry FIFO. The FSM pops one command
// at a time. It drives registered operand/select/shift values to the ALU and waits ALU_LAT settle
// cycles after an EXEC. It then captures the ALU result and flags into a valid/ready result port
// and keeps a sticky OR of all captured flags.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ena                         global enable; freezes FSM and FIFO push/pop when low
//   cmd_valid/cmd_ready         command handshake
//   cmd_type/data/op/shift      command fields (00 LOAD_A, 01 LOAD_B, 10 EXEC, 11 CLEAR)
//   alu_a/alu_b/alu_s/alu_shift registered ALU inputs
//   alu_y, alu_zero/carry/overflow  ALU result and flags (combinational from alu_*)
//   res_valid/res_ready         result handshake
//   res_y, res_flags            captured result and {overflow, carry, zero}
//   sticky_flags                OR of captured flags since reset/CLEAR
//   busy                        FSM not idle or FIFO non-empty
//   q_level                     FIFO occupancy
module alu_cmd_sequencer #(
  parameter int unsigned QDEPTH  = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_type,
  input  logic [7:0]              cmd_data,
  input  logic [2:0]              cmd_op,
  input  logic [3:0]              cmd_shift,
  output logic [7:0]              alu_a,
  output logic [7:0]              alu_b,
  output logic [2:0]              alu_s,
  output logic [3:0]              alu_shift,
  input  logic [7:0]              alu_y,
  input  logic                    alu_zero,
  input  logic                    alu_carry,
  input  logic                    alu_overflow,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [7:0]              res_y,
  output logic [2:0]              res_flags,
  output logic [2:0]              sticky_flags,
  output logic                    busy,
  output logic [$clog2(QDEPTH):0] q_level
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CntInit   = CW'(ALU_LAT - 1);
  localparam logic [AW:0]   LevelFull = (AW + 1)'(QDEPTH);

  localparam logic [1:0] CmdLoadA = 2'b00;
  localparam logic [1:0] CmdLoadB = 2'b01;
  localparam logic [1:0] CmdExec  = 2'b10;
  localparam logic [1:0] CmdClear = 2'b11;

  typedef enum logic [2:0] {StIdle, StDecode, StSettle, StCapture, StHold} state_e;

  state_e state_q, state_d;

  // FIFO: entry = {type, data, op, shift}
  logic [16:0]   mem_q [QDEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          fifo_empty, fifo_full, push, pop;

  logic [16:0]   cur_q, cur_d;
  logic [7:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]    alu_s_q, alu_s_d;
  logic [3:0]    alu_shift_q, alu_shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    res_y_q, res_y_d;
  logic [2:0]    res_flags_q, res_flags_d;
  logic [2:0]    sticky_q, sticky_d;
  logic          capture;

  logic [1:0] cur_type;
  logic [7:0] cur_data;
  logic [2:0] cur_op;
  logic [3:0] cur_shift;

  assign cur_type  = cur_q[16:15];
  assign cur_data  = cur_q[14:7];
  assign cur_op    = cur_q[6:4];
  assign cur_shift = cur_q[3:0];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == LevelFull);
  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign cmd_ready  = ena && !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = ena && (state_q == StIdle) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_type, cmd_data, cmd_op, cmd_shift};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (ena) begin
      unique case (state_q)
        StIdle:    if (!fifo_empty) state_d = StDecode;
        StDecode:  state_d = (cur_type == CmdExec) ? StSettle : StIdle;
        StSettle:  if (cnt_q == '0) state_d = StCapture;
        // An unconsumed result parks the FSM in HOLD with ALU inputs untouched.
        StCapture,
        StHold:    state_d = res_valid_q ? StHold : StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Capture uses the registered res_valid, so it can never coincide with a consumer handshake.
  assign capture = ena && ((state_q == StCapture) || (state_q == StHold)) && !res_valid_q;

  // FSM outputs / datapath next values
  always_comb begin
    cur_d       = cur_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    alu_shift_d = alu_shift_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_y_d     = res_y_q;
    res_flags_d = res_flags_q;
    sticky_d    = sticky_q;

    if (pop) cur_d = mem_q[rd_ptr_q];

    if (ena && (state_q == StDecode)) begin
      unique case (cur_type)
        CmdLoadA: alu_a_d = cur_data;
        CmdLoadB: alu_b_d = cur_data;
        CmdExec: begin
          alu_s_d     = cur_op;
          alu_shift_d = cur_shift;
          cnt_d       = CntInit;
        end
        CmdClear: begin
          alu_a_d     = '0;
          alu_b_d     = '0;
          alu_s_d     = '0;
          alu_shift_d = '0;
          sticky_d    = '0;
        end
        default: ;
      endcase
    end

    if (ena && (state_q == StSettle) && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;

    // The result handshake is the consumer's, so it is honoured even while ena is low.
    if (res_valid_q && res_ready) res_valid_d = 1'b0;

    if (capture) begin
      res_y_d     = alu_y;
      res_flags_d = {alu_overflow, alu_carry, alu_zero};
      sticky_d    = sticky_q | {alu_overflow, alu_carry, alu_zero};
      res_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      alu_shift_q <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_flags_q <= '0;
      sticky_q    <= '0;
    end else begin
      cur_q       <= cur_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      alu_shift_q <= alu_shift_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_y_q     <= res_y_d;
      res_flags_q <= res_flags_d;
      sticky_q    <= sticky_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_s        = alu_s_q;
  assign alu_shift    = alu_shift_q;
  assign res_valid    = res_valid_q;
  assign res_y        = res_y_q;
  assign res_flags    = res_flags_q;
  assign sticky_flags = sticky_q;
  assign busy         = (state_q != StIdle) || !fifo_empty;
  assign q_level      = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
`timescale 1ns/1ps
// Testbench for alu_cmd_sequencer: directed scenarios followed by randomized commands.
// A behavioural ALU drives the DUT's ALU inputs, and a command-level model predicts each
// result at command acceptance. A separate monitor pops the predictions as results appear.
module tb_alu_cmd_sequencer;

  localparam int unsigned QD  = 4;
  localparam int unsigned LAT = 3;
  localparam int unsigned LW  = $clog2(QD) + 1;

  logic          clk = 1'b0;
  logic          rst_n, ena, cmd_valid, cmd_ready;
  logic [1:0]    cmd_type;
  logic [7:0]    cmd_data;
  logic [2:0]    cmd_op;
  logic [3:0]    cmd_shift;
  logic [7:0]    alu_a, alu_b, alu_y;
  logic [2:0]    alu_s;
  logic [3:0]    alu_shift;
  logic          alu_zero, alu_carry, alu_overflow;
  logic          res_valid, res_ready;
  logic [7:0]    res_y;
  logic [2:0]    res_flags, sticky_flags;
  logic          busy;
  logic [LW-1:0] q_level;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.QDEPTH(QD), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_data(cmd_data),
    .cmd_op(cmd_op), .cmd_shift(cmd_shift),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_shift(alu_shift),
    .alu_y(alu_y), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_flags(res_flags),
    .sticky_flags(sticky_flags), .busy(busy), .q_level(q_level)
  );

  // Bench ALU: returns {overflow, carry, zero, y}
  function automatic logic [10:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] s, input logic [3:0] sh);
    logic [8:0] w;
    logic [7:0] y;
    logic       c, v;
    w = '0; c = 1'b0; v = 1'b0; y = '0;
    case (s)
      3'd0: begin
        w = {1'b0, a} + {1'b0, b}; y = w[7:0]; c = w[8];
        v = (a[7] == b[7]) && (y[7] != a[7]);
      end
      3'd1: begin
        w = {1'b0, a} - {1'b0, b}; y = w[7:0]; c = w[8];
        v = (a[7] != b[7]) && (y[7] != a[7]);
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = a << sh;
      3'd6: y = a >> sh;
      default: y = ~a;
    endcase
    return {v, c, (y == 8'h00), y};
  endfunction

  assign {alu_overflow, alu_carry, alu_zero, alu_y} = alu_fn(alu_a, alu_b, alu_s, alu_shift);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Command-level model, updated in acceptance order
  typedef struct {
    logic [7:0] y;
    logic [2:0] f;
    logic [2:0] st;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_a, m_b;
  logic [2:0] m_s, m_sticky;
  logic [3:0] m_sh;
  logic [10:0] m_r;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_a = '0; m_b = '0; m_s = '0; m_sh = '0; m_sticky = '0;
    end else if (cmd_valid && cmd_ready) begin
      case (cmd_type)
        2'b00: m_a = cmd_data;
        2'b01: m_b = cmd_data;
        2'b10: begin
          m_s  = cmd_op;
          m_sh = cmd_shift;
          m_r  = alu_fn(m_a, m_b, cmd_op, cmd_shift);
          m_sticky = m_sticky | m_r[10:8];
          sb.push_back('{y: m_r[7:0], f: m_r[10:8], st: m_sticky});
        end
        default: begin
          m_a = '0; m_b = '0; m_s = '0; m_sh = '0; m_sticky = '0;
        end
      endcase
    end
  end

  // Monitor: every rising edge of res_valid is one new result
  logic prev_v = 1'b0;
  exp_t mon_e;
  int   n_results = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v <= 1'b0;
    end else begin
      if (res_valid && !prev_v) begin
        n_results++;
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_result: got res_y 0x%0h with no result expected", res_y);
        end else begin
          mon_e = sb.pop_front();
          chk("res_y", 32'(res_y), 32'(mon_e.y));
          chk("res_flags", 32'(res_flags), 32'(mon_e.f));
          chk("sticky_at_capture", 32'(sticky_flags), 32'(mon_e.st));
        end
      end
      prev_v <= res_valid;
    end
  end

  task automatic send_cmd(input logic [1:0] t, input logic [7:0] d, input logic [2:0] op,
                          input logic [3:0] sh, input bit rnd);
    int   w;
    logic acc;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_type = t; cmd_data = d; cmd_op = op; cmd_shift = sh;
    acc = 1'b0; w = 0;
    while (!acc && w < 200) begin
      if (rnd) begin
        ena       = ($urandom_range(0, 3) != 0);
        res_ready = $urandom_range(0, 1) != 0;
      end
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #1; w++;
    end
    cmd_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout: got no cmd_ready required one within 200 cycles");
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    do begin
      @(negedge clk); w++;
    end while (busy && w < 400);
    if (busy) begin
      n_checks++;
      n_err++;
      $display("FAIL idle_timeout: got busy=1 required 0");
    end
  endtask

  task automatic check_model();
    chk("alu_a", 32'(alu_a), 32'(m_a));
    chk("alu_b", 32'(alu_b), 32'(m_b));
    chk("alu_s", 32'(alu_s), 32'(m_s));
    chk("alu_shift", 32'(alu_shift), 32'(m_sh));
    chk("sticky", 32'(sticky_flags), 32'(m_sticky));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_alu_a"}, 32'(alu_a), 0);
    chk({tag, "_alu_b"}, 32'(alu_b), 0);
    chk({tag, "_alu_s"}, 32'(alu_s), 0);
    chk({tag, "_alu_shift"}, 32'(alu_shift), 0);
    chk({tag, "_res_valid"}, 32'(res_valid), 0);
    chk({tag, "_res_y"}, 32'(res_y), 0);
    chk({tag, "_res_flags"}, 32'(res_flags), 0);
    chk({tag, "_sticky"}, 32'(sticky_flags), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_q_level"}, 32'(q_level), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n, w;
    bit  done;
    int  t;
    rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; res_ready = 1'b1;
    cmd_type = '0; cmd_data = '0; cmd_op = '0; cmd_shift = '0;
    #23;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // Scenario 1: basic add and EXEC latency
    send_cmd(2'b00, 8'h3C, 3'd0, 4'd0, 0);
    send_cmd(2'b01, 8'h0F, 3'd0, 4'd0, 0);
    wait_idle();
    send_cmd(2'b10, 8'h00, 3'd0, 4'd0, 0);
    n = 0; done = 0;
    while (!done && n < 50) begin
      @(posedge clk); n++;
      @(negedge clk); done = res_valid;
    end
    chk("exec_latency", 32'(n), 32'(3 + LAT));
    wait_idle();
    chk("s1_alu_a", 32'(alu_a), 32'h3C);
    chk("s1_alu_b", 32'(alu_b), 32'h0F);
    chk("s1_res_y", 32'(res_y), 32'h4B);
    chk("s1_res_flags", 32'(res_flags), 32'h0);

    // Scenario 2: carry/zero then overflow
    send_cmd(2'b00, 8'hFF, 3'd0, 4'd0, 0);
    send_cmd(2'b01, 8'h01, 3'd0, 4'd0, 0);
    send_cmd(2'b10, 8'h00, 3'd0, 4'd0, 0);
    wait_idle();
    chk("s2a_res_y", 32'(res_y), 32'h00);
    chk("s2a_res_flags", 32'(res_flags), 32'b011);
    send_cmd(2'b00, 8'h7F, 3'd0, 4'd0, 0);
    send_cmd(2'b10, 8'h00, 3'd0, 4'd0, 0);
    wait_idle();
    chk("s2b_res_y", 32'(res_y), 32'h80);
    chk("s2b_res_flags", 32'(res_flags), 32'b100);
    chk("s2b_sticky", 32'(sticky_flags), 32'b111);
    check_model();

    // Scenario 4: CLEAR keeps the last result
    send_cmd(2'b11, 8'hAA, 3'd5, 4'd7, 0);
    wait_idle();
    chk("clr_alu_a", 32'(alu_a), 0);
    chk("clr_alu_b", 32'(alu_b), 0);
    chk("clr_alu_s", 32'(alu_s), 0);
    chk("clr_alu_shift", 32'(alu_shift), 0);
    chk("clr_sticky", 32'(sticky_flags), 0);
    chk("clr_res_y_kept", 32'(res_y), 32'h80);

    // Scenario 5: ena low for 4 cycles during SETTLE
    send_cmd(2'b00, 8'h20, 3'd0, 4'd0, 0);
    send_cmd(2'b01, 8'h05, 3'd0, 4'd0, 0);
    wait_idle();
    send_cmd(2'b10, 8'h00, 3'd1, 4'd0, 0);
    n = 0; done = 0;
    while (!done && n < 50) begin
      @(posedge clk); n++; #1;
      if (n == 3) ena = 1'b0;
      if (n == 7) ena = 1'b1;
      @(negedge clk);
      if (n == 4) begin
        chk("frozen_cmd_ready", 32'(cmd_ready), 0);
        chk("frozen_busy", 32'(busy), 1);
      end
      done = res_valid;
    end
    chk("ena_latency", 32'(n), 32'(3 + LAT + 4));
    wait_idle();
    chk("s5_res_y", 32'(res_y), 32'h1B);

    // Scenario 3: back-pressure, FSM parks in HOLD, FIFO fills
    res_ready = 1'b0;
    send_cmd(2'b00, 8'h96, 3'd0, 4'd0, 0);
    for (int i = 0; i < int'(QD) + 2; i++) begin
      send_cmd(2'b10, 8'h00, 3'(i + 1), 4'(i), 0);
    end
    repeat (4) @(negedge clk);
    chk("full_q_level", 32'(q_level), 32'(QD));
    chk("full_cmd_ready", 32'(cmd_ready), 0);
    for (int i = 0; i < int'(QD) + 2; i++) begin
      w = 0;
      do begin
        @(negedge clk); w++;
      end while (!res_valid && w < 100);
      if (!res_valid) begin
        n_checks++;
        n_err++;
        $display("FAIL result_timeout: got res_valid=0 required 1 (result %0d)", i);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
    end
    res_ready = 1'b1;
    wait_idle();
    chk("hold_all_delivered", 32'(sb.size()), 0);

    // Scenario 6: asynchronous reset mid-SETTLE with two commands queued
    send_cmd(2'b10, 8'h00, 3'd0, 4'd0, 0);
    send_cmd(2'b00, 8'h11, 3'd0, 4'd0, 0);
    send_cmd(2'b01, 8'h22, 3'd0, 4'd0, 0);
    chk("pre_reset_q_level", 32'(q_level), 2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_cmd(2'b00, 8'h55, 3'd0, 4'd0, 0);
    wait_idle();
    chk("post_reset_alu_a", 32'(alu_a), 32'h55);
    check_model();

    // Randomized phase: random commands, ena and res_ready
    for (int i = 0; i < 120; i++) begin
      t = int'($urandom_range(0, 9));
      if (t <= 2)      send_cmd(2'b00, 8'($urandom), 3'($urandom), 4'($urandom), 1);
      else if (t <= 5) send_cmd(2'b01, 8'($urandom), 3'($urandom), 4'($urandom), 1);
      else if (t <= 8) send_cmd(2'b10, 8'($urandom), 3'($urandom), 4'($urandom), 1);
      else             send_cmd(2'b11, 8'($urandom), 3'($urandom), 4'($urandom), 1);
    end
    ena = 1'b1;
    res_ready = 1'b1;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("rand_all_delivered", 32'(sb.size()), 0);
    check_model();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
